// File: rtl/detector_jogada.sv
// detector_jogada: player-button front end. Synchronises the raw button
// vector, waits for it to stay stable, and turns each accepted press into
// one 'jogada' pulse with a held one-hot button code. A stable multi-key
// pattern gives one 'jogada_invalida' pulse instead. After either pulse,
// every key must be released for a full debounce window before the next
// press can be recognised.
module detector_jogada #(
    parameter int N_BOTOES        = 4,
    parameter int DEBOUNCE_CICLOS = 1000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [N_BOTOES-1:0] botoes,
    output logic                jogada,
    output logic [N_BOTOES-1:0] jogada_valor,
    output logic                jogada_invalida,
    output logic [3:0]          db_estado
);

    localparam int CNT_W = $clog2(DEBOUNCE_CICLOS);

    localparam logic [CNT_W-1:0]    CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0]    CNT_UM    = CNT_W'(1);
    localparam logic [CNT_W-1:0]    CNT_MAX   = CNT_W'(DEBOUNCE_CICLOS - 1);
    localparam logic [N_BOTOES-1:0] BOT_ZERO  = N_BOTOES'(0);
    localparam logic [N_BOTOES-1:0] BOT_UM    = N_BOTOES'(1);

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        FILTRA  = 3'd1,
        PULSO   = 3'd2,
        REJEITA = 3'd3,
        SOLTA   = 3'd4
    } estado_t;

    // True when exactly one bit of the pattern is set.
    function automatic logic ehUmQuente(input logic [N_BOTOES-1:0] v);
        logic [N_BOTOES-1:0] menosUm;
        menosUm = v - BOT_UM;
        return (v != BOT_ZERO) && ((v & menosUm) == BOT_ZERO);
    endfunction

    // True for the encodings the FSM actually uses.
    function automatic logic estadoValido(input estado_t e);
        logic ok;
        case (e)
            OCIOSO, FILTRA, PULSO, REJEITA, SOLTA: ok = 1'b1;
            default:                               ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Debug code shown for a given state.
    function automatic logic [3:0] codigoEstado(input estado_t e);
        logic [3:0] c;
        case (e)
            OCIOSO:  c = 4'h0;
            FILTRA:  c = 4'h1;
            PULSO:   c = 4'h2;
            REJEITA: c = 4'h3;
            SOLTA:   c = 4'h4;
            default: c = 4'hF;
        endcase
        return c;
    endfunction

    logic [N_BOTOES-1:0] sync1_r;
    logic [N_BOTOES-1:0] bs_r;
    logic [N_BOTOES-1:0] amostra_r;
    logic [N_BOTOES-1:0] amostra_s;
    logic [CNT_W-1:0]    cnt_r;
    logic [CNT_W-1:0]    cnt_s;
    estado_t             estado_r;
    estado_t             proximo_s;
    logic                jogada_r;
    logic                invalida_r;
    logic [N_BOTOES-1:0] valor_r;
    logic [N_BOTOES-1:0] valor_s;
    logic [3:0]          dbEstado_r;

    // Two-flop synchroniser bringing the asynchronous buttons into the clock domain.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_r <= BOT_ZERO;
            bs_r    <= BOT_ZERO;
        end else begin
            sync1_r <= botoes;
            bs_r    <= sync1_r;
        end
    end

    // Next-state, counter, sample and held-code logic of the press FSM.
    always_comb begin
        proximo_s = estado_r;
        cnt_s     = cnt_r;
        amostra_s = amostra_r;
        valor_s   = valor_r;
        case (estado_r)
            OCIOSO: begin
                cnt_s = CNT_ZERO;
                if (bs_r != BOT_ZERO) begin
                    amostra_s = bs_r;
                    proximo_s = FILTRA;
                end else begin
                    proximo_s = OCIOSO;
                end
            end
            FILTRA: begin
                if (bs_r != amostra_r) begin
                    // Pattern moved: start over so the final stable pattern decides.
                    cnt_s     = CNT_ZERO;
                    proximo_s = OCIOSO;
                end else if (cnt_r < CNT_MAX) begin
                    cnt_s = cnt_r + CNT_UM;
                end else if (ehUmQuente(amostra_r)) begin
                    cnt_s     = CNT_ZERO;
                    valor_s   = amostra_r;
                    proximo_s = PULSO;
                end else begin
                    cnt_s     = CNT_ZERO;
                    proximo_s = REJEITA;
                end
            end
            PULSO: begin
                cnt_s     = CNT_ZERO;
                proximo_s = SOLTA;
            end
            REJEITA: begin
                cnt_s     = CNT_ZERO;
                proximo_s = SOLTA;
            end
            SOLTA: begin
                // Any key still down restarts the release window.
                if (bs_r != BOT_ZERO) begin
                    cnt_s = CNT_ZERO;
                end else if (cnt_r == CNT_MAX) begin
                    cnt_s     = CNT_ZERO;
                    proximo_s = OCIOSO;
                end else begin
                    cnt_s = cnt_r + CNT_UM;
                end
            end
            default: begin
                cnt_s     = CNT_ZERO;
                proximo_s = OCIOSO;
            end
        endcase
    end

    // State, counter and sample registers of the press FSM.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_r  <= OCIOSO;
            cnt_r     <= CNT_ZERO;
            amostra_r <= BOT_ZERO;
        end else begin
            estado_r  <= proximo_s;
            cnt_r     <= cnt_s;
            amostra_r <= amostra_s;
        end
    end

    // Registered outputs; they reflect the state entered on the same edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            jogada_r   <= 1'b0;
            invalida_r <= 1'b0;
            valor_r    <= BOT_ZERO;
            dbEstado_r <= 4'h0;
        end else begin
            jogada_r   <= (proximo_s == PULSO);
            invalida_r <= (proximo_s == REJEITA);
            valor_r    <= valor_s;
            // A corrupted state encoding is flagged for one cycle while recovering.
            dbEstado_r <= estadoValido(estado_r) ? codigoEstado(proximo_s) : 4'hF;
        end
    end

    assign jogada          = jogada_r;
    assign jogada_invalida = invalida_r;
    assign jogada_valor    = valor_r;
    assign db_estado       = dbEstado_r;

endmodule
